serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor that computes D = X - Y LSB-first, one bit per clock. It uses a single full-subtractor cell and a borrow flip-flop, which makes it the inverse-operation, sequential counterpart of the combinational full-adder datapath. It sits in the lab arithmetic datapath as an area-minimal subtract unit with a start/done handshake. Results are registered and held until the next completed operation.

Parameters:
WIDTH, 8, operand and result width in bits (legal: >= 1)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_ni  input  1  asynchronous, active-low reset
start_i  input  1  request a new subtraction; honoured only in IDLE
x_i  input  WIDTH  minuend, sampled on the accepting edge
y_i  input  WIDTH  subtrahend, sampled on the accepting edge
busy_o  output  1  high while an operation is in progress (RUN or DONE)
done_o  output  1  one-cycle pulse: d_o/b_o/ovf_o just updated
d_o  output  WIDTH  difference X - Y modulo 2^WIDTH
b_o  output  1  final borrow out (1 when X < Y as unsigned)
ovf_o  output  1  signed two's-complement overflow of X - Y

Behaviour:
- Interface: one clock (clk_i); reset rst_ni is asynchronous, active-low.
- Reset (asserted at any time, including mid-operation):
  - state = IDLE; busy_o = 0, done_o = 0, d_o = 0, b_o = 0, ovf_o = 0.
  - Internal shift registers, borrow flop and bit counter cleared.
  - An in-flight operation is abandoned, with no partial result visible.
- FSM states IDLE, RUN, DONE:
  - IDLE: start_i = 1 at an edge loads x_i and y_i into shift registers, clears borrow to 0, clears the counter to 0, latches the operand MSBs for overflow, and moves to RUN. start_i = 0 keeps IDLE.
  - RUN: each edge consumes bit 0 of both shift registers (xb, yb, current borrow bw).
    - Difference bit = xb ^ yb ^ bw, shifted into the result register from the MSB end.
    - Next borrow = (~xb & yb) | (~(xb ^ yb) & bw).
    - Operand registers shift right by 1; counter increments.
    - On the edge processing bit WIDTH-1, go to DONE. The same edge loads d_o from the completed result, b_o from the final borrow, and ovf_o = (xmsb ^ ymsb) & (xmsb ^ d_msb).
  - DONE: done_o = 1 for exactly this cycle; next edge returns to IDLE unconditionally.
- Latency: the accepting edge is E0. Outputs update and done_o rises after edge E0+WIDTH. done_o falls after E0+WIDTH+1. The earliest next accept is E0+WIDTH+2. Throughput is one operation per WIDTH+2 cycles.
- busy_o is 1 in RUN and DONE, and 0 in IDLE. It is a registered state decode with no combinational path from start_i.
- start_i in RUN or DONE is ignored. It is not queued, and x_i/y_i are not re-sampled.
- x_i and y_i may change freely after the accepting edge.
- d_o, b_o and ovf_o change only on the DONE-entry edge or on reset. Between operations they hold their last value.
- Counter width is clog2(WIDTH+1) bits; no wrap occurs within a valid operation.
- WIDTH = 1: RUN lasts one edge, and ovf_o = (x ^ y) & (x ^ d).
- All outputs are driven directly from flops.

Test Plan:
- WIDTH=8, reset, start with x=5, y=3 -> done_o 8 cycles after the accept edge; d_o=0x02, b_o=0, ovf_o=0; busy_o high for 9 cycles.
- x=3, y=5 -> d_o=0xFE, b_o=1, ovf_o=0; x=0x80, y=0x01 -> d_o=0x7F, b_o=0, ovf_o=1; x=0x7F, y=0xFF -> d_o=0x80, b_o=1, ovf_o=1.
- x=0x00, y=0x00, then x=0xFF, y=0xFF back-to-back, with start_i held high continuously -> two done pulses exactly 10 cycles apart, both results d_o=0x00, b_o=0, ovf_o=0.
- Start with x=9, y=4; pulse start_i with x=0xAA, y=0x55 during RUN and during DONE -> single result d_o=0x05; no second operation begins.
- Start with x=0x40, y=0x10; assert rst_ni low asynchronously after 4 RUN cycles -> all outputs 0 immediately, IDLE; a new start with x=1, y=2 -> d_o=0xFF, b_o=1.
- Randomised sweep at WIDTH=1, 8 and 13 against the reference model (x - y) mod 2^W, borrow = x < y, signed overflow -> zero mismatches, and done_o is always exactly one cycle wide.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = X - Y computed LSB-first, one bit per clock,
// with a single full-subtractor cell and a borrow flop.
//
// Ports:
//   clk_i    - clock, all state updates on the rising edge
//   rst_ni   - asynchronous active-low reset
//   start_i  - request a new subtraction, honoured only in IDLE
//   x_i      - minuend, sampled on the accepting edge
//   y_i      - subtrahend, sampled on the accepting edge
//   busy_o   - high while an operation is in RUN or DONE
//   done_o   - one-cycle pulse, d_o/b_o/ovf_o were just updated
//   d_o      - difference X - Y modulo 2^WIDTH
//   b_o      - final borrow out (X < Y as unsigned)
//   ovf_o    - signed two's-complement overflow of X - Y
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] d_o,
    output logic             b_o,
    output logic             ovf_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] x_sr;
    logic [WIDTH-1:0] y_sr;
    logic [WIDTH-1:0] res_sr;
    logic             bw;
    logic [CNT_W-1:0] cnt;
    logic             xmsb;
    logic             ymsb;

    logic             xb;
    logic             yb;
    logic             dbit;
    logic             bw_next;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    // Full-subtractor cell on the current LSBs plus result shift-in.
    always_comb begin
        xb       = x_sr[0];
        yb       = y_sr[0];
        dbit     = xb ^ yb ^ bw;
        bw_next  = (~xb & yb) | (~(xb ^ yb) & bw);
        last_bit = (cnt == CNT_W'(WIDTH - 1));
        // Difference bits enter at the MSB so bit 0 ends up at the LSB.
        res_next = (res_sr >> 1) | (WIDTH'(dbit) << (WIDTH - 1));
    end

    // Control FSM and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            x_sr   <= '0;
            y_sr   <= '0;
            res_sr <= '0;
            bw     <= 1'b0;
            cnt    <= '0;
            xmsb   <= 1'b0;
            ymsb   <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            d_o    <= '0;
            b_o    <= 1'b0;
            ovf_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        x_sr   <= x_i;
                        y_sr   <= y_i;
                        res_sr <= '0;
                        bw     <= 1'b0;
                        cnt    <= '0;
                        xmsb   <= x_i[WIDTH-1];
                        ymsb   <= y_i[WIDTH-1];
                        busy_o <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    x_sr   <= x_sr >> 1;
                    y_sr   <= y_sr >> 1;
                    res_sr <= res_next;
                    bw     <= bw_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        // dbit here is the MSB of the finished difference.
                        d_o    <= res_next;
                        b_o    <= bw_next;
                        ovf_o  <= (xmsb ^ ymsb) & (xmsb ^ dbit);
                        done_o <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor at WIDTH = 1, 8, 13.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        s1, busy1, done1, b1, o1;
    logic [0:0]  x1, y1, d1;
    logic        s8, busy8, done8, b8, o8;
    logic [7:0]  x8, y8, d8;
    logic        s13, busy13, done13, b13, o13;
    logic [12:0] x13, y13, d13;

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(s1), .x_i(x1), .y_i(y1),
        .busy_o(busy1), .done_o(done1), .d_o(d1), .b_o(b1), .ovf_o(o1)
    );
    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(s8), .x_i(x8), .y_i(y8),
        .busy_o(busy8), .done_o(done8), .d_o(d8), .b_o(b8), .ovf_o(o8)
    );
    serial_subtractor #(.WIDTH(13)) dut13 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(s13), .x_i(x13), .y_i(y13),
        .busy_o(busy13), .done_o(done13), .d_o(d13), .b_o(b13), .ovf_o(o13)
    );

    function automatic logic get_done(input int w);
        case (w)
            1:       return done1;
            13:      return done13;
            default: return done8;
        endcase
    endfunction

    // Drive one instance's inputs (truncating to its width).
    task automatic drive(input int w, input logic st, input logic [15:0] x, input logic [15:0] y);
        case (w)
            1:       begin s1 = st;  x1 = x[0:0];   y1 = y[0:0];   end
            13:      begin s13 = st; x13 = x[12:0]; y13 = y[12:0]; end
            default: begin s8 = st;  x8 = x[7:0];   y8 = y[7:0];   end
        endcase
    endtask

    // Start one op, return outputs, accept-to-done cycles and done one cycle later.
    task automatic do_op(input int w, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] d, output logic b, output logic ovf,
                         output int cycles, output logic done_after);
        drive(w, 1'b1, x, y);
        @(posedge clk); #1;
        drive(w, 1'b0, 16'h0, 16'h0);
        cycles = 0;
        while (!get_done(w) && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!get_done(w)) cycles = -1;
        case (w)
            1:       begin d = 16'(d1);  b = b1;  ovf = o1;  end
            13:      begin d = 16'(d13); b = b13; ovf = o13; end
            default: begin d = 16'(d8);  b = b8;  ovf = o8;  end
        endcase
        @(posedge clk); #1;
        done_after = get_done(w);
    endtask

    // Independent reference: integer arithmetic and signed range test.
    task automatic model(input int w, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] d, output logic b, output logic ovf);
        int m, xi, yi, sx, sy, r;
        m  = 1 << w;
        xi = int'(x) % m;
        yi = int'(y) % m;
        d  = 16'((xi - yi + m) % m);
        b  = (xi < yi);
        sx = (xi >= m / 2) ? xi - m : xi;
        sy = (yi >= m / 2) ? yi - m : yi;
        r  = sx - sy;
        ovf = (r < -(m / 2)) || (r > m / 2 - 1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 1'b0, 16'h0, 16'h0);
        drive(8, 1'b0, 16'h0, 16'h0);
        drive(13, 1'b0, 16'h0, 16'h0);
        #13;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done8); end
        checks++; if (d8 !== 8'h00) begin errors++; $display("FAIL reset_d got=%h exp=00", d8); end
        checks++; if ({b8, o8} !== 2'b00) begin errors++; $display("FAIL reset_b_ovf got=%b exp=00", {b8, o8}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int cycles, busy_cnt;
        drive(8, 1'b1, 16'd5, 16'd3);
        @(posedge clk); #1;
        drive(8, 1'b0, 16'h0, 16'h0);
        cycles = 0;
        busy_cnt = busy8 ? 1 : 0;
        while (!done8 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
            if (busy8) busy_cnt++;
        end
        checks++; if (cycles != 8) begin errors++; $display("FAIL basic_latency got=%0d exp=8", cycles); end
        checks++; if (d8 !== 8'h02) begin errors++; $display("FAIL basic_d got=%h exp=02", d8); end
        checks++; if ({b8, o8} !== 2'b00) begin errors++; $display("FAIL basic_b_ovf got=%b exp=00", {b8, o8}); end
        @(posedge clk); #1;
        if (busy8) busy_cnt++;
        checks++; if (busy_cnt != 9) begin errors++; $display("FAIL basic_busy_len got=%0d exp=9", busy_cnt); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL basic_done_width got=%b exp=0", done8); end
    endtask

    task automatic test_borrow_ovf();
        logic [7:0]  tx [3] = '{8'h03, 8'h80, 8'h7F};
        logic [7:0]  ty [3] = '{8'h05, 8'h01, 8'hFF};
        logic [7:0]  td [3] = '{8'hFE, 8'h7F, 8'h80};
        logic [1:0]  tbo[3] = '{2'b10, 2'b01, 2'b11};
        logic [15:0] d;
        logic        b, ovf, da;
        int          cyc;
        for (int i = 0; i < 3; i++) begin
            do_op(8, 16'(tx[i]), 16'(ty[i]), d, b, ovf, cyc, da);
            checks++; if (d[7:0] !== td[i]) begin errors++; $display("FAIL vec%0d_d got=%h exp=%h", i, d[7:0], td[i]); end
            checks++; if ({b, ovf} !== tbo[i]) begin errors++; $display("FAIL vec%0d_b_ovf got=%b exp=%b", i, {b, ovf}, tbo[i]); end
            checks++; if (cyc != 8) begin errors++; $display("FAIL vec%0d_latency got=%0d exp=8", i, cyc); end
        end
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        drive(8, 1'b1, 16'h00, 16'h00);
        @(posedge clk); #1;
        drive(8, 1'b1, 16'hFF, 16'hFF);
        c1 = 0;
        while (!done8 && c1 < 40) begin @(posedge clk); #1; c1++; end
        checks++; if (c1 != 8) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=8", c1); end
        checks++; if ({d8, b8, o8} !== 10'h000) begin errors++; $display("FAIL b2b_first_result got=%h/%b/%b exp=00/0/0", d8, b8, o8); end
        c2 = 0;
        @(posedge clk); #1; c2++;
        while (!done8 && c2 < 40) begin @(posedge clk); #1; c2++; end
        drive(8, 1'b0, 16'h0, 16'h0);
        checks++; if (c2 != 10) begin errors++; $display("FAIL b2b_spacing got=%0d exp=10", c2); end
        checks++; if ({d8, b8, o8} !== 10'h000) begin errors++; $display("FAIL b2b_second_result got=%h/%b/%b exp=00/0/0", d8, b8, o8); end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_ignore_start();
        int cycles, busy_seen;
        drive(8, 1'b1, 16'd9, 16'd4);
        @(posedge clk); #1;
        drive(8, 1'b0, 16'h0, 16'h0);
        cycles = 0;
        repeat (3) begin @(posedge clk); #1; cycles++; end
        drive(8, 1'b1, 16'hAA, 16'h55);
        @(posedge clk); #1; cycles++;
        drive(8, 1'b0, 16'hAA, 16'h55);
        while (!done8 && cycles < 40) begin @(posedge clk); #1; cycles++; end
        checks++; if (cycles != 8) begin errors++; $display("FAIL ignore_latency got=%0d exp=8", cycles); end
        drive(8, 1'b1, 16'hAA, 16'h55);
        @(posedge clk); #1;
        drive(8, 1'b0, 16'h0, 16'h0);
        checks++; if (d8 !== 8'h05) begin errors++; $display("FAIL ignore_d got=%h exp=05", d8); end
        busy_seen = 0;
        repeat (12) begin @(posedge clk); #1; if (busy8 || done8) busy_seen++; end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL ignore_no_second_op got=%0d exp=0", busy_seen); end
        checks++; if (d8 !== 8'h05) begin errors++; $display("FAIL ignore_d_hold got=%h exp=05", d8); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        logic        b, ovf, da;
        int          cyc;
        drive(8, 1'b1, 16'h40, 16'h10);
        @(posedge clk); #1;
        drive(8, 1'b0, 16'h0, 16'h0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy8, done8} !== 2'b00) begin errors++; $display("FAIL midrst_busy_done got=%b exp=00", {busy8, done8}); end
        checks++; if ({d8, b8, o8} !== 10'h000) begin errors++; $display("FAIL midrst_outputs got=%h/%b/%b exp=00/0/0", d8, b8, o8); end
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL midrst_idle got=%b exp=0", busy8); end
        do_op(8, 16'd1, 16'd2, d, b, ovf, cyc, da);
        checks++; if ({d[7:0], b, ovf} !== {8'hFF, 1'b1, 1'b0}) begin errors++; $display("FAIL midrst_new_op got=%h/%b/%b exp=ff/1/0", d[7:0], b, ovf); end
    endtask

    task automatic test_sweep();
        int          widths[3] = '{1, 8, 13};
        logic [15:0] x, y, d, ed;
        logic        b, ovf, eb, eo, da;
        int          cyc, n;
        for (int wi = 0; wi < 3; wi++) begin
            n = (widths[wi] == 1) ? 4 : 24;
            for (int i = 0; i < n; i++) begin
                if (widths[wi] == 1) begin
                    x = 16'(i & 1);
                    y = 16'((i >> 1) & 1);
                end else begin
                    x = 16'($urandom);
                    y = 16'($urandom);
                end
                model(widths[wi], x, y, ed, eb, eo);
                do_op(widths[wi], x, y, d, b, ovf, cyc, da);
                checks++;
                if ({d, b, ovf} !== {ed, eb, eo} || cyc != widths[wi] || da !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_w%0d x=%h y=%h got=%h/%b/%b lat=%0d done_after=%b exp=%h/%b/%b lat=%0d done_after=0",
                             widths[wi], x, y, d, b, ovf, cyc, da, ed, eb, eo, widths[wi]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_ovf();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
